// File: rtl/instr_fetch_stage.sv
// Instruction-fetch front end. Owns the fetch PC, drives the word-addressed instruction
// memory and produces the IF/ID register. A one-entry skid buffer makes stalls, redirects and halts lossless.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        halted_o
);

  logic [31:0] r_pc_f;
  logic        r_inflight_v;
  logic [31:0] r_inflight_pc;
  logic        r_skid_v;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_valid_d;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_halted;

  logic w_blocked;
  logic w_resp;
  logic w_req;
  logic w_accept_halt;

  assign w_blocked = stall_i && r_valid_d;
  assign w_resp    = r_inflight_v && !r_halted && !redirect_i;
  // Never issue while a response could find both D and the skid entry occupied.
  assign w_req     = !r_halted && !redirect_i && !r_skid_v && !(w_blocked && r_inflight_v);
  // Every arriving response lands in D or the skid, so any response is an accepted one.
  assign w_accept_halt = w_resp && (imem_rdata == HALT_WORD);

  assign imem_req  = w_req;
  assign imem_addr = {2'b00, r_pc_f[31:2]};
  assign instrD    = r_instr_d;
  assign pcD       = r_pc_d;
  assign pc_plus4D = r_pc_d + 32'd4;
  assign validD    = r_valid_d;
  assign halted_o  = r_halted;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f        <= RESET_PC;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= 32'd0;
      r_halted      <= 1'b0;
    end else if (redirect_i) begin
      r_pc_f       <= {redirect_pc_i[31:2], 2'b00};
      r_inflight_v <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      if (w_req) begin
        r_pc_f        <= r_pc_f + 32'd4;
        r_inflight_pc <= r_pc_f;
        r_inflight_v  <= 1'b1;
      end else begin
        r_inflight_v <= 1'b0;
      end
      if (w_accept_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_v     <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_valid_d    <= 1'b0;
      r_instr_d    <= 32'd0;
      r_pc_d       <= 32'd0;
    end else if (redirect_i) begin
      r_skid_v  <= 1'b0;
      r_valid_d <= 1'b0;
      r_instr_d <= 32'd0;
    end else if (w_blocked) begin
      if (w_resp) begin
        r_skid_v     <= 1'b1;
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_inflight_pc;
      end
    end else if (r_skid_v) begin
      r_valid_d <= 1'b1;
      r_instr_d <= r_skid_instr;
      r_pc_d    <= r_skid_pc;
      r_skid_v  <= w_resp;
      if (w_resp) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_inflight_pc;
      end
    end else if (w_resp) begin
      r_valid_d <= 1'b1;
      r_instr_d <= imem_rdata;
      r_pc_d    <= r_inflight_pc;
    end else begin
      // Bubbles are never held: an empty D simply stays empty.
      r_valid_d <= 1'b0;
      r_instr_d <= 32'd0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: table-driven directed vectors, hand-written halt/wrap/reset
// sequences, then random stall/redirect traffic against a queue-based reference model.
module tb_instr_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;
  logic        halted_o;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D),
    .validD(validD), .halted_o(halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // memory contents: mode 0 = 0x1000_0000 + word address (optional halt word), mode 1 = hashed
  int          mem_mode = 0;
  bit          halt_en  = 1'b0;
  logic [31:0] halt_wa  = 32'd0;
  logic [31:0] mem_seed = 32'h5A5A_1234;

  function automatic logic [31:0] imem_word(input logic [31:0] wa);
    logic [31:0] h;
    if (mem_mode == 0) begin
      if (halt_en && wa == halt_wa) return HALT;
      return 32'h1000_0000 + wa;
    end
    h = (wa * 32'h9E37_79B1) ^ mem_seed;
    if (h[4:0] == 5'd7) return HALT;
    return h;
  endfunction

  logic [31:0] r_rdata;
  always @(negedge clk) r_rdata <= imem_req ? imem_word(imem_addr) : 32'hDEAD_BEEF;
  assign imem_rdata = r_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_halted;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins, input logic h);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.exp_req = q; t.exp_addr = a;
    t.exp_valid = v; t.exp_pc = pc; t.exp_instr = ins; t.exp_halted = h;
    return t;
  endfunction

  // Inputs applied at posedge, imem_req checked in the same cycle, D checked after the falling edge.
  task automatic apply_vec(input vec_t v, input string tag, input int idx);
    string nm;
    @(posedge clk);
    stall_i = v.stall; redirect_i = v.redir; redirect_pc_i = v.rpc;
    #1;
    nm = $sformatf("%s[%0d]", tag, idx);
    chk({nm, ".imem_req"}, imem_req, v.exp_req);
    if (v.exp_req) chk({nm, ".imem_addr"}, imem_addr, v.exp_addr);
    @(negedge clk);
    #1;
    stall_i = 1'b0; redirect_i = 1'b0;
    chk({nm, ".validD"}, validD, v.exp_valid);
    chk({nm, ".instrD"}, instrD, v.exp_valid ? v.exp_instr : 32'd0);
    if (v.exp_valid) begin
      chk({nm, ".pcD"}, pcD, v.exp_pc);
      chk({nm, ".pc_plus4D"}, pc_plus4D, v.exp_pc + 32'd4);
    end
    chk({nm, ".halted_o"}, halted_o, v.exp_halted);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } entry_t;
  logic [31:0] m_pc_f;
  bit          m_inf;
  logic [31:0] m_inf_pc;
  entry_t      m_skid[$];
  entry_t      m_d;
  bit          m_dv;
  bit          m_halted;

  task automatic model_reset();
    m_pc_f = 32'd0; m_inf = 1'b0; m_inf_pc = 32'd0;
    m_skid.delete(); m_d = '0; m_dv = 1'b0; m_halted = 1'b0;
  endtask

  function automatic bit model_req(input bit st, input bit rd);
    return !m_halted && !rd && (m_skid.size() == 0) && !(st && m_dv && m_inf);
  endfunction

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rp, input bit req);
    entry_t r;
    bit     have;
    bit     nh;
    if (rd) begin
      m_pc_f = {rp[31:2], 2'b00};
      m_inf = 1'b0; m_skid.delete(); m_dv = 1'b0; m_halted = 1'b0;
      return;
    end
    have    = m_inf && !m_halted;
    r.pc    = m_inf_pc;
    r.instr = imem_word({2'b00, m_inf_pc[31:2]});
    nh      = have && (r.instr == HALT);
    if (st && m_dv) begin
      if (have) m_skid.push_back(r);
    end else if (m_skid.size() > 0) begin
      m_d = m_skid.pop_front(); m_dv = 1'b1;
      if (have) m_skid.push_back(r);
    end else if (have) begin
      m_d = r; m_dv = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
    if (req) begin
      m_inf = 1'b1; m_inf_pc = m_pc_f; m_pc_f = m_pc_f + 32'd4;
    end else begin
      m_inf = 1'b0;
    end
    if (nh) m_halted = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    @(posedge clk);
    #1;
    chk("rst.validD", validD, 1'b0);
    chk("rst.instrD", instrD, 32'd0);
    chk("rst.pcD", pcD, 32'd0);
    chk("rst.pc_plus4D", pc_plus4D, 32'd4);
    chk("rst.halted_o", halted_o, 1'b0);
    chk("rst.imem_addr", imem_addr, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        seq[$];
    logic        st;
    logic        rd;
    logic [31:0] rp;
    logic        exp_req;

    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

    // stall for 3 cycles at pcD=8, release, then redirect to 0x43 while stalled
    tbl.push_back(mk(0, 0, 0,        1, 32'h0,  0, 32'h0,  32'h0,         0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h1,  1, 32'h0,  32'h1000_0000, 0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h2,  1, 32'h4,  32'h1000_0001, 0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h3,  1, 32'h8,  32'h1000_0002, 0));
    tbl.push_back(mk(1, 0, 0,        0, 32'h0,  1, 32'h8,  32'h1000_0002, 0));
    tbl.push_back(mk(1, 0, 0,        0, 32'h0,  1, 32'h8,  32'h1000_0002, 0));
    tbl.push_back(mk(1, 0, 0,        0, 32'h0,  1, 32'h8,  32'h1000_0002, 0));
    tbl.push_back(mk(0, 0, 0,        0, 32'h0,  1, 32'hC,  32'h1000_0003, 0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h4,  0, 32'h0,  32'h0,         0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h5,  1, 32'h10, 32'h1000_0004, 0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h6,  1, 32'h14, 32'h1000_0005, 0));
    tbl.push_back(mk(1, 0, 0,        0, 32'h0,  1, 32'h14, 32'h1000_0005, 0));
    tbl.push_back(mk(1, 1, 32'h43,   0, 32'h0,  0, 32'h0,  32'h0,         0));
    tbl.push_back(mk(1, 0, 0,        1, 32'h10, 0, 32'h0,  32'h0,         0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h11, 1, 32'h40, 32'h1000_0010, 0));
    tbl.push_back(mk(0, 0, 0,        1, 32'h12, 1, 32'h44, 32'h1000_0011, 0));

    mem_mode = 0; halt_en = 1'b0;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], "tbl", i);

    // halt word at imem[3], then redirect to 0 resumes fetch
    halt_en = 1'b1; halt_wa = 32'd3;
    do_reset();
    seq.delete();
    seq.push_back(mk(0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0,         0));
    seq.push_back(mk(0, 0, 0, 1, 32'h1, 1, 32'h0, 32'h1000_0000, 0));
    seq.push_back(mk(0, 0, 0, 1, 32'h2, 1, 32'h4, 32'h1000_0001, 0));
    seq.push_back(mk(0, 0, 0, 1, 32'h3, 1, 32'h8, 32'h1000_0002, 0));
    seq.push_back(mk(0, 0, 0, 1, 32'h4, 1, 32'hC, HALT,          1));
    seq.push_back(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0,         1));
    seq.push_back(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0,         1));
    seq.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0,         0));
    seq.push_back(mk(0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0,         0));
    seq.push_back(mk(0, 0, 0, 1, 32'h1, 1, 32'h0, 32'h1000_0000, 0));
    for (int i = 0; i < seq.size(); i++) apply_vec(seq[i], "halt", i);

    // redirect to the top of the address space wraps to 0
    halt_en = 1'b0;
    seq.delete();
    seq.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         32'h0,         0));
    seq.push_back(mk(0, 0, 0,             1, 32'h3FFF_FFFF, 0, 32'h0,         32'h0,         0));
    seq.push_back(mk(0, 0, 0,             1, 32'h0,         1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 0));
    seq.push_back(mk(0, 0, 0,             1, 32'h1,         1, 32'h0,         32'h1000_0000, 0));
    for (int i = 0; i < seq.size(); i++) apply_vec(seq[i], "wrap", i);
    #1 chk("wrap.pc_plus4D_at_top", pc_plus4D, 32'h4);

    // asynchronous reset mid-stall with the skid entry full
    do_reset();
    for (int i = 0; i < 5; i++) apply_vec(tbl[i], "arst_fill", i);
    @(posedge clk);
    stall_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.validD", validD, 1'b0);
    chk("arst.instrD", instrD, 32'd0);
    chk("arst.pcD", pcD, 32'd0);
    chk("arst.pc_plus4D", pc_plus4D, 32'd4);
    chk("arst.halted_o", halted_o, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 4; i++) apply_vec(tbl[i], "arst_restart", i);

    // random stall/redirect traffic with hashed memory and occasional halt words
    mem_mode = 1;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      st = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 15) == 0);
      rp = $urandom;
      stall_i = st; redirect_i = rd; redirect_pc_i = rp;
      exp_req = model_req(st, rd);
      #1;
      chk("rnd.imem_req", imem_req, exp_req);
      if (exp_req) chk("rnd.imem_addr", imem_addr, {2'b00, m_pc_f[31:2]});
      @(negedge clk);
      model_step(st, rd, rp, exp_req);
      #1;
      chk("rnd.validD", validD, m_dv);
      chk("rnd.instrD", instrD, m_dv ? m_d.instr : 32'd0);
      if (m_dv) chk("rnd.pcD", pcD, m_d.pc);
      if (m_dv) chk("rnd.pc_plus4D", pc_plus4D, m_d.pc + 32'd4);
      chk("rnd.halted_o", halted_o, m_halted);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
